// File: rtl/exec_stage.sv
// Y86-64 execute stage: drives the shared ALU, owns the ZF/SF/OF register and
// evaluates jump/cmov conditions, returning one registered result per instruction.

module alu (
    input  logic [1:0]  select,
    input  logic [63:0] p,
    input  logic [63:0] q,
    output logic [63:0] r,
    output logic        ofw
);
    always_comb begin
        r   = '0;
        ofw = 1'b0;
        unique case (select)
            2'd0: begin
                r   = p + q;
                ofw = (p[63] == q[63]) && (r[63] != p[63]);
            end
            2'd1: begin
                r   = p - q;
                ofw = (p[63] != q[63]) && (r[63] != p[63]);
            end
            2'd2: r = p & q;
            2'd3: r = p ^ q;
            default: r = '0;
        endcase
    end
endmodule

module exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic        out_err
);
    typedef enum logic [3:0] {
        I_HALT = 4'h0, I_NOP  = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
        I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
        I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB
    } icode_e;

    typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_XOR = 2'd3} alu_sel_e;

    logic        out_valid_q;
    logic [63:0] valE_q, valE_d;
    logic        cnd_q, cnd_d;
    logic        err_q, err_d;
    logic [2:0]  cc_q, cc_d;

    alu_sel_e    alu_sel;
    logic [63:0] alu_p, alu_q, alu_r;
    logic        alu_of;
    logic        use_alu;
    logic        cond_met;
    logic        accept;

    alu u_alu (
        .select (alu_sel),
        .p      (alu_p),
        .q      (alu_q),
        .r      (alu_r),
        .ofw    (alu_of)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Condition evaluated against the CC value held before this instruction.
    always_comb begin
        cond_met = 1'b0;
        unique case (ifun)
            4'd0:    cond_met = 1'b1;
            4'd1:    cond_met = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'd2:    cond_met = cc_q[1] ^ cc_q[0];
            4'd3:    cond_met = cc_q[2];
            4'd4:    cond_met = !cc_q[2];
            4'd5:    cond_met = !(cc_q[1] ^ cc_q[0]);
            4'd6:    cond_met = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
            default: cond_met = 1'b0;
        endcase
    end

    always_comb begin
        alu_sel = ALU_ADD;
        alu_p   = '0;
        alu_q   = '0;
        use_alu = 1'b0;
        cnd_d   = 1'b0;
        err_d   = 1'b0;
        unique case (icode)
            I_HALT, I_NOP: ;
            I_RRMOV: begin
                alu_q   = valA;
                use_alu = 1'b1;
                err_d   = (ifun > 4'd6);
                cnd_d   = cond_met;
            end
            I_IRMOV: begin
                alu_q   = valC;
                use_alu = 1'b1;
            end
            I_RMMOV, I_MRMOV: begin
                alu_p   = valB;
                alu_q   = valC;
                use_alu = 1'b1;
            end
            I_OPQ: begin
                alu_sel = alu_sel_e'(ifun[1:0]);
                alu_p   = valB;
                alu_q   = valA;
                use_alu = 1'b1;
                err_d   = (ifun > 4'd3);
            end
            I_JXX: begin
                err_d = (ifun > 4'd6);
                cnd_d = cond_met;
            end
            I_CALL, I_PUSH: begin
                alu_sel = ALU_SUB;
                alu_p   = valB;
                alu_q   = 64'd8;
                use_alu = 1'b1;
            end
            I_RET, I_POP: begin
                alu_p   = valB;
                alu_q   = 64'd8;
                use_alu = 1'b1;
            end
            default: err_d = 1'b1;
        endcase

        valE_d = (use_alu && !err_d) ? alu_r : '0;
        if (err_d) cnd_d = 1'b0;
        cc_d = cc_q;
        if (icode == I_OPQ && !err_d) cc_d = {(alu_r == '0), alu_r[63], alu_of};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            valE_q      <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= 3'b100;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            valE_q      <= valE_d;
            cnd_q       <= cnd_d;
            err_q       <= err_d;
            cc_q        <= cc_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = valE_q;
    assign cnd       = cnd_q;
    assign out_err   = err_q;
    assign cc        = cc_q;
endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: directed cases followed by random instructions, each
// compared with a behavioural model of the Y86 execute rules.

module tb_exec_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  icode, ifun;
    logic [63:0] valA, valB, valC, valE;
    logic        cnd, out_err;
    logic [2:0]  cc;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    logic [2:0]  m_cc;
    logic [63:0] e_ve;
    logic        e_cn, e_er;
    logic [2:0]  e_cc;

    exec_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .out_valid(out_valid), .out_ready(out_ready), .valE(valE),
        .cnd(cnd), .cc(cc), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true signed overflow is detected with a 65-bit sum.
    task automatic model(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [2:0] cci, output logic [63:0] ve, output logic cn,
                         output logic er, output logic [2:0] cco);
        logic [64:0] wide;
        logic [63:0] r;
        logic        of, zf, sf, ov, lt;
        {zf, sf, ov} = cci;
        lt  = (sf != ov);
        ve  = '0; cn = 1'b0; er = 1'b0; cco = cci;
        r   = '0; of = 1'b0; wide = '0;
        case (ic)
            4'h0, 4'h1: ;
            4'h2, 4'h7: begin
                if (fn > 6) er = 1'b1;
                else begin
                    case (fn)
                        0: cn = 1'b1;
                        1: cn = lt || zf;
                        2: cn = lt;
                        3: cn = zf;
                        4: cn = !zf;
                        5: cn = !lt;
                        default: cn = !lt && !zf;
                    endcase
                    if (ic == 4'h2) ve = a;
                end
            end
            4'h3: ve = c;
            4'h4, 4'h5: ve = b + c;
            4'h8, 4'hA: ve = b - 64'd8;
            4'h9, 4'hB: ve = b + 64'd8;
            4'h6: begin
                if (fn > 3) er = 1'b1;
                else begin
                    case (fn)
                        0: begin wide = {b[63], b} + {a[63], a}; r = wide[63:0]; of = wide[64] != wide[63]; end
                        1: begin wide = {b[63], b} - {a[63], a}; r = wide[63:0]; of = wide[64] != wide[63]; end
                        2: r = b & a;
                        default: r = b ^ a;
                    endcase
                    ve  = r;
                    cco = {(r == 64'd0), r[63], of};
                end
            end
            default: er = 1'b1;
        endcase
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        in_valid = 1'b1;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, ".valE"}, valE, e_ve);
        chk({tag, ".cnd"}, {63'd0, cnd}, {63'd0, e_cn});
        chk({tag, ".err"}, {63'd0, out_err}, {63'd0, e_er});
        chk({tag, ".cc"}, {61'd0, cc}, {61'd0, e_cc});
    endtask

    task automatic send(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        model(ic, fn, a, b, c, m_cc, e_ve, e_cn, e_er, e_cc);
        drive(ic, fn, a, b, c);
        out_ready = 1'b1;
        @(posedge clk); #1;
        m_cc = e_cc;
        in_valid = 1'b0;
        check_out(tag);
    endtask

    initial begin
        logic [63:0] held_ve;
        logic [2:0]  held_cc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
        m_cc = 3'b100;
        #12;
        chk("rst.valid", {63'd0, out_valid}, 64'd0);
        chk("rst.valE", valE, 64'd0);
        chk("rst.cnd", {63'd0, cnd}, 64'd0);
        chk("rst.err", {63'd0, out_err}, 64'd0);
        chk("rst.cc", {61'd0, cc}, 64'd4);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        send("add", 4'h6, 4'h0, 64'd69, 64'd96, 64'd0);
        chk("add.valE_const", valE, 64'd165);
        send("sub", 4'h6, 4'h1, 64'd9, 64'd6, 64'd0);
        chk("sub.valE_const", valE, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("sub.cc_const", {61'd0, cc}, 64'd2);
        send("jl", 4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        chk("jl.cnd_const", {63'd0, cnd}, 64'd1);
        send("je", 4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        send("ovf", 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        chk("ovf.cc_const", {61'd0, cc}, 64'd3);
        send("ovf_jl", 4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        send("ovf_jg", 4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
        send("push", 4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        chk("push.valE_const", valE, 64'hF8);
        send("pop", 4'hB, 4'h0, 64'd0, 64'hF8, 64'd0);
        send("mrmov", 4'h5, 4'h0, 64'd0, 64'd34, 64'd56);
        chk("mrmov.valE_const", valE, 64'd90);
        chk("nonop.cc_const", {61'd0, cc}, 64'd3);

        @(posedge clk); #1;
        chk("drain.valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: hold a completed result while a new one waits.
        send("bp_first", 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
        held_ve = e_ve; held_cc = e_cc;
        out_ready = 1'b0;
        drive(4'h6, 4'h3, 64'hFF00, 64'h0FF0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            #0;
            chk("bp.in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            chk("bp.valid", {63'd0, out_valid}, 64'd1);
            chk("bp.valE", valE, held_ve);
            chk("bp.cc", {61'd0, cc}, {61'd0, held_cc});
        end
        model(4'h6, 4'h3, 64'hFF00, 64'h0FF0, 64'd0, m_cc, e_ve, e_cn, e_er, e_cc);
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_cc = e_cc;
        check_out("bp_second");
        @(posedge clk); #1;
        chk("bp.no_dup", {63'd0, out_valid}, 64'd0);

        send("err_icode", 4'hD, 4'h0, 64'd5, 64'd6, 64'd7);
        chk("err_icode.const", {63'd0, out_err}, 64'd1);
        send("err_opq", 4'h6, 4'h5, 64'd5, 64'd6, 64'd7);
        send("err_jxx", 4'h7, 4'h7, 64'd0, 64'd0, 64'd0);

        for (int n = 0; n < 200; n++) begin
            logic [3:0]  ric, rfn;
            logic [63:0] ra, rb, rc;
            ric = 4'($urandom_range(0, 15));
            rfn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            ra  = {$urandom, $urandom};
            rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            rc  = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                chk("rand.idle", {63'd0, out_valid}, 64'd0);
            end
            send("rand", ric, rfn, ra, rb, rc);
        end

        send("pre_rst", 4'h6, 4'h1, 64'd1, 64'd1, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", {63'd0, out_valid}, 64'd0);
        chk("arst.cc", {61'd0, cc}, 64'd4);
        chk("arst.valE", valE, 64'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
